// File: rtl/mac_pkg.sv
// Shared constants and FSM state type for the triplet MAC transmit/check path.
package mac_pkg;

  localparam int unsigned MAC_W = 32;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    SEND_A,
    SEND_B,
    SEND_C
  } tx_state_t;

endpackage

// File: rtl/mac_exp_fifo.sv
// Expected-result FIFO: first-word fall-through read, registered full/empty flags.
module mac_exp_fifo
  import mac_pkg::*;
#(
  parameter int unsigned W     = MAC_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_full;
  logic          r_empty;
  logic          w_push;
  logic          w_pop;
  logic [AW:0]   w_count_nxt;

  assign w_push      = push && !r_full;
  assign w_pop       = pop && !r_empty;
  assign w_count_nxt = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= wr_data;
    end
  end

  // Flags are computed from next occupancy so they stay registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign rd_data = r_mem[r_rptr];
  assign full    = r_full;
  assign empty   = r_empty;

endmodule

// File: rtl/mac_triplet_tx.sv
// Serializes (a,b,c) triples onto a word stream and checks returned a*b+c results
// in order against a queue of expectations, keeping saturating statistics.
module mac_triplet_tx
  import mac_pkg::*;
#(
  parameter int unsigned W     = MAC_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [W-1:0]     in_c,
  output logic             tx_valid,
  output logic [W-1:0]     tx_data,
  input  logic             res_valid,
  input  logic [W-1:0]     res_data,
  output logic             busy,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             err
);

  tx_state_t        r_state;
  tx_state_t        w_state_nxt;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_c;
  logic             r_tx_valid;
  logic [W-1:0]     r_tx_data;
  logic             w_tx_valid_nxt;
  logic [W-1:0]     w_tx_data_nxt;
  logic             w_accept;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic [W-1:0]     w_exp;
  logic [W-1:0]     w_exp_head;
  logic [CNT_W-1:0] r_match;
  logic [CNT_W-1:0] r_mismatch;
  logic             r_err;

  assign in_ready = ((r_state == IDLE) || (r_state == SEND_C)) && !w_full;
  assign w_accept = in_valid && in_ready;
  assign w_exp    = in_a * in_b + in_c;
  assign w_pop    = res_valid && !w_empty;

  mac_exp_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_exp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (w_accept),
    .wr_data (w_exp),
    .pop     (w_pop),
    .rd_data (w_exp_head),
    .full    (w_full),
    .empty   (w_empty)
  );

  // Stream word is chosen from the next state so tx_data is a register that
  // already holds operand a on the accept edge.
  always_comb begin
    w_state_nxt   = r_state;
    w_tx_data_nxt = '0;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = SEND_A;
      SEND_A:  w_state_nxt = SEND_B;
      SEND_B:  w_state_nxt = SEND_C;
      SEND_C:  w_state_nxt = w_accept ? SEND_A : IDLE;
      default: w_state_nxt = IDLE;
    endcase
    case (w_state_nxt)
      SEND_A:  w_tx_data_nxt = w_accept ? in_a : r_a;
      SEND_B:  w_tx_data_nxt = r_b;
      SEND_C:  w_tx_data_nxt = r_c;
      default: w_tx_data_nxt = '0;
    endcase
    w_tx_valid_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_c        <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_tx_data  <= w_tx_data_nxt;
      if (w_accept) begin
        r_a <= in_a;
        r_b <= in_b;
        r_c <= in_c;
      end
    end
  end

  // A result arriving with nothing outstanding counts as a mismatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_match    <= '0;
      r_mismatch <= '0;
      r_err      <= 1'b0;
    end else if (res_valid) begin
      if (!w_empty && (res_data == w_exp_head)) begin
        if (r_match != '1) r_match <= r_match + 1'b1;
      end else begin
        if (r_mismatch != '1) r_mismatch <= r_mismatch + 1'b1;
        r_err <= 1'b1;
      end
    end
  end

  assign tx_valid     = r_tx_valid;
  assign tx_data      = r_tx_data;
  assign busy         = (r_state != IDLE) || !w_empty;
  assign match_cnt    = r_match;
  assign mismatch_cnt = r_mismatch;
  assign err          = r_err;

endmodule

// File: tb/tb_mac_triplet_tx.sv
// Scoreboard bench for mac_triplet_tx: directed triples and returned results.
module tb_mac_triplet_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [31:0] in_c = '0;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        res_valid = 1'b0;
  logic [31:0] res_data = '0;
  logic        busy;
  logic [15:0] match_cnt;
  logic [15:0] mismatch_cnt;
  logic        err;

  mac_triplet_tx #(
    .W     (32),
    .DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_c         (in_c),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .busy         (busy),
    .match_cnt    (match_cnt),
    .mismatch_cnt (mismatch_cnt),
    .err          (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned m;
    int unsigned mm;
    logic        e;
  } cnt_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] txq[$];
  cnt_t        rq[$];
  int unsigned m_match = 0;
  int unsigned m_mis = 0;
  logic        m_err = 1'b0;
  int          run = 0;
  int          last_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: stream words and post-result counters against queued expectations.
  initial begin : monitor
    logic        rv;
    cnt_t        e;
    logic [31:0] w;
    forever begin
      @(posedge clk);
      rv = res_valid;
      @(negedge clk);
      if (tx_valid) begin
        run++;
        if (txq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got word %0h expected no word", tx_data);
        end else begin
          w = txq.pop_front();
          check("tx_data", tx_data, w);
        end
      end else if (run != 0) begin
        last_run = run;
        run = 0;
      end
      if (rv) begin
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL res_unexpected: counter update with no queued expectation");
        end else begin
          e = rq.pop_front();
          check("match_cnt", {16'b0, match_cnt}, e.m);
          check("mismatch_cnt", {16'b0, mismatch_cnt}, e.mm);
          check("err", {31'b0, err}, {31'b0, e.e});
        end
      end
    end
  end

  task automatic offer(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    int cyc;
    @(negedge clk);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_c = c;
    cyc = 0;
    while (!in_ready && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1 for a=%0h", a);
      in_valid = 1'b0;
    end else begin
      txq.push_back(a);
      txq.push_back(b);
      txq.push_back(c);
      @(posedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic ret(input logic [31:0] r, input bit is_match);
    cnt_t e;
    @(negedge clk);
    res_valid = 1'b1;
    res_data = r;
    if (is_match) m_match++;
    else begin
      m_mis++;
      m_err = 1'b1;
    end
    e.m = m_match;
    e.mm = m_mis;
    e.e = m_err;
    rq.push_back(e);
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while ((txq.size() != 0 || rq.size() != 0) && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    if (txq.size() != 0 || rq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending tx %0d res %0d expected 0 0", txq.size(), rq.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_state();
    check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("rst_tx_data", tx_data, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_match", {16'b0, match_cnt}, 32'd0);
    check("rst_mismatch", {16'b0, mismatch_cnt}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    #12;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;

    // Basic round trip
    offer(32'd3, 32'd4, 32'd5);
    idle();
    drain();
    check("run_single", 32'(last_run), 32'd3);
    check("busy_pending", {31'b0, busy}, 32'd1);
    ret(32'd17, 1'b1);
    drain();
    check("busy_clear", {31'b0, busy}, 32'd0);

    // Back-to-back
    offer(32'd1, 32'd2, 32'd3);
    offer(32'd2, 32'd5, 32'd7);
    idle();
    drain();
    check("run_b2b", 32'(last_run), 32'd6);
    ret(32'd5, 1'b1);
    ret(32'd17, 1'b1);
    drain();

    // Mismatch then unexpected
    offer(32'd3, 32'd4, 32'd5);
    idle();
    drain();
    ret(32'd18, 1'b0);
    ret(32'd99, 1'b0);
    drain();

    // Wrap
    offer(32'hFFFF_FFFF, 32'd2, 32'd1);
    idle();
    drain();
    ret(32'hFFFF_FFFF, 1'b1);
    drain();

    // Full queue blocks the fifth triple
    offer(32'd1, 32'd1, 32'd0);
    offer(32'd2, 32'd2, 32'd0);
    offer(32'd3, 32'd3, 32'd0);
    offer(32'd4, 32'd4, 32'd0);
    @(negedge clk);
    in_a = 32'd5;
    in_b = 32'd5;
    in_c = 32'd0;
    repeat (12) @(negedge clk);
    check("full_in_ready", {31'b0, in_ready}, 32'd0);
    check("full_busy", {31'b0, busy}, 32'd1);
    in_valid = 1'b0;
    ret(32'd1, 1'b1);
    @(negedge clk);
    check("refill_in_ready", {31'b0, in_ready}, 32'd1);
    offer(32'd5, 32'd5, 32'd0);
    idle();
    drain();
    ret(32'd4, 1'b1);
    ret(32'd9, 1'b1);
    ret(32'd16, 1'b1);
    ret(32'd25, 1'b1);
    drain();

    // Reset during SEND_B
    offer(32'd3, 32'd4, 32'd5);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst_n = 1'b0;
    txq.delete();
    m_match = 0;
    m_mis = 0;
    m_err = 1'b0;
    #1;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    offer(32'd3, 32'd4, 32'd5);
    idle();
    drain();
    check("run_after_rst", 32'(last_run), 32'd3);
    ret(32'd17, 1'b1);
    drain();
    check("final_busy", {31'b0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_triplet_tx.md
# mac_triplet_tx

Transmit side and checker for the triplet multiply-accumulate stream. The block accepts parallel operand triples (a, b, c) over a valid/ready handshake and serializes them onto a 32-bit word stream as three consecutive valid words. That stream drives the triplet MAC receiver's `validi`/`data_in`. For each triple the block queues the expected result a*b+c. It then checks results returned by the receiver in order and keeps match/mismatch statistics for the lab bench and top-level self-test.

## Interface
Parameters:
- `W`, 32: data width of operands, stream and results.
- `DEPTH`, 4: number of expected-result entries outstanding; power of two, ≥2.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand triple offered.
- `in_ready` out 1: block can accept a triple this cycle.
- `in_a`, `in_b`, `in_c` in W each: operands; sampled on accept.
- `tx_valid` out 1: stream word valid; connects to receiver `validi`.
- `tx_data` out W: stream word; connects to receiver `data_in`.
- `res_valid` in 1: one returned result per cycle it is high.
- `res_data` in W: returned result.
- `busy` out 1: FSM not in IDLE, or expected-result queue not empty.
- `match_cnt` out 16: results equal to expectation; saturating.
- `mismatch_cnt` out 16: wrong or unexpected results; saturating.
- `err` out 1: sticky; set on any mismatch or unexpected result.

## Operation
- FSM states are IDLE, SEND_A, SEND_B and SEND_C.
  - IDLE goes to SEND_A on accept.
  - SEND_A goes to SEND_B, and SEND_B goes to SEND_C, unconditionally.
  - SEND_C goes to SEND_A on accept, otherwise to IDLE.
- Accept is `in_valid && in_ready`.
- `in_ready` is high only when the state is IDLE or SEND_C and the queue is not full (registered occupancy).
  - A triple cannot be accepted in SEND_A or SEND_B.
- On accept:
  - Latch a, b and c.
  - Push `(in_a*in_b + in_c) mod 2^W` (unsigned, low W bits) into the expected queue.
- Stream output:
  - `tx_valid`=1 in SEND_A, SEND_B and SEND_C, and 0 in IDLE.
  - `tx_data` is a, b and c respectively; it is 0 in IDLE.
  - Back-to-back accepts keep `tx_valid` continuously high, with the triplet phase preserved.
- Result check, on `res_valid`:
  - Queue non-empty: pop and compare. Equal increments `match_cnt`. Unequal increments `mismatch_cnt` and sets `err`.
  - Queue empty: this is an unexpected result. Increment `mismatch_cnt`, set `err`, pop nothing.
- Simultaneous push and pop are allowed; occupancy is unchanged. A push and a `res_valid` on an empty queue in the same cycle count as unexpected; the push still lands.
- Counters saturate at 16'hFFFF.
- `err` clears only on reset.
- Reset, including mid-triple:
  - State goes to IDLE and the queue empties.
  - `tx_valid`, `tx_data`, counters and `err` go to 0.
  - `in_ready` goes high (queue empty, IDLE).

## Timing
- Accept at edge k: `tx_data`=a from edge k through edge k+1, then b, then c. `tx_valid` is high for exactly 3 cycles per triple.
- Maximum throughput is one triple per 3 cycles.
- All outputs are registered, except `in_ready`, which is a combinational decode of state and registered full flag.
- The check result is visible in `match_cnt`/`mismatch_cnt`/`err` one cycle after the `res_valid` edge.
- Result return latency from the receiver is unconstrained; ordering is strict FIFO.
- Assertion of `rst_n` low forces outputs immediately, without waiting for a clock.

## Structure
- Package `mac_pkg` holds:
  - the `W` default constant;
  - the `tx_state_t` enum (IDLE, SEND_A, SEND_B, SEND_C);
  - the counter width constant (16).
- Sub-module `mac_exp_fifo` is a synchronous FIFO, W wide and DEPTH deep, with push, pop, full, empty and rd_data (first-word fall-through) and the same clock/reset. The top holds the FSM, operand registers, comparator and counters.

## Test plan
- Basic round trip, with a=3, b=4, c=5 accepted once:
  - `tx_data` is 3, 4, 5 with `tx_valid` high for 3 cycles.
  - Returning `res_data`=17 gives `match_cnt`=1 and `err`=0.
- Back-to-back: triples (1,2,3) and (2,5,7) with `in_valid` held high.
  - `tx_valid` is high for 6 consecutive cycles.
  - Returning 5 then 17 gives `match_cnt`=2.
- Mismatch and unexpected:
  - Return 18 for (3,4,5): `mismatch_cnt`=1 and `err`=1.
  - A further `res_valid` with the queue empty gives `mismatch_cnt`=2.
- Wrap and full:
  - a=32'hFFFF_FFFF, b=2, c=1 expects 32'hFFFF_FFFF.
  - With DEPTH=4 and no returns, the 5th triple is not accepted (`in_ready`=0).
  - One return re-enables accept.
- Reset mid-operation: drop `rst_n` during SEND_B.
  - `tx_valid` goes 0 at once, the queue empties, and counters and `err` go to 0.
  - After release, (3,4,5) returns 17 and gives `match_cnt`=1.
